// File: rtl/par_rx9_pkg.sv
// Shared types and helpers for the par_rx9 parity-checked serial receiver.
package par_rx9_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int ERRCNT_W = 8;

    // 8-input XOR parity cell; narrower characters tie their upper inputs to 0.
    function automatic logic par_chk(input logic [7:0] data, input logic pbit, input logic odd);
        return (^data) ^ pbit ^ odd;
    endfunction

endpackage

// File: rtl/par_rx9_if.sv
// Holding-register handshake between par_rx9 (master) and its consumer (slave).
interface par_rx9_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] DOUT;
    logic              PERR;
    logic              FERR;
    logic              DVALID;
    logic              DREADY;
    logic              OVR;

    modport master (output DOUT, PERR, FERR, DVALID, OVR, input DREADY);
    modport slave  (input DOUT, PERR, FERR, DVALID, OVR, output DREADY);
endinterface

// File: rtl/par_rx9_shift.sv
// LSB-first data shift register with a terminal-count down-counter; done pulses
// combinationally on the strobe that shifts in the last data bit.
module par_rx9_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              en_i,
    input  logic              sin_i,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (start_i) begin
            cnt_d = CNT_LAST;
            sh_d  = '0;
        end else if (en_i) begin
            sh_d = {sin_i, sh_q[DATA_W-1:1]};
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

    assign data_o = sh_q;
    assign done_o = en_i & ~start_i & (cnt_q == '0);
endmodule

// File: rtl/par_rx9.sv
// Parity-checked serial character receiver with a one-entry holding register.
// Optional saturating error counter enabled by PAR_RX9_ERRCNT_EN.
//   state | meaning
//   IDLE  | waiting for a start bit (SIN=0 on a BIT_EN strobe)
//   DATA  | shifting in DATA_W data bits, LSB first
//   PAR   | sampling the parity bit
//   STOP  | sampling the stop bit, then committing the character
module par_rx9
    import par_rx9_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PAR_ODD = 0
) (
    input  logic       C,
    input  logic       R_N,
    input  logic       BIT_EN,
    input  logic       SIN,
    output logic       BUSY,
    par_rx9_if.master  rx
`ifdef PAR_RX9_ERRCNT_EN
    ,
    input  logic                ERRCLR,
    output logic [ERRCNT_W-1:0] ERRCNT
`endif
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              dvalid_q, dvalid_d;
    logic              ovr_q, ovr_d;
    logic              pfr_q, pfr_d;

    logic [DATA_W-1:0] sh_data;
    logic              sh_done;
    logic              commit, rd, load;

    par_rx9_shift #(.DATA_W(DATA_W)) u_shift (
        .clk     (C),
        .rst_n   (R_N),
        .start_i (BIT_EN & (state_q == IDLE) & ~SIN),
        .en_i    (BIT_EN & (state_q == DATA)),
        .sin_i   (SIN),
        .data_o  (sh_data),
        .done_o  (sh_done)
    );

    assign commit = BIT_EN & (state_q == STOP);
    assign rd     = dvalid_q & rx.DREADY;
    assign load   = commit & (~dvalid_q | rd);

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        dvalid_d = dvalid_q;
        ovr_d    = ovr_q;
        pfr_d    = pfr_q;
        case (state_q)
            IDLE: if (BIT_EN && !SIN) state_d = DATA;
            DATA: if (sh_done) state_d = PAR;
            PAR: if (BIT_EN) begin
                pfr_d   = par_chk(8'(sh_data), SIN, PAR_ODD != 0);
                state_d = STOP;
            end
            STOP: if (BIT_EN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rd) begin
            dvalid_d = 1'b0;
            ovr_d    = 1'b0;
        end
        // A full, unread register drops the new character instead of overwriting it.
        if (load) begin
            dout_d   = sh_data;
            perr_d   = pfr_q;
            ferr_d   = ~SIN;
            dvalid_d = 1'b1;
        end else if (commit) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge C) begin
        if (!R_N) begin
            state_q  <= IDLE;
            dout_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            dvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            pfr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            dvalid_q <= dvalid_d;
            ovr_q    <= ovr_d;
            pfr_q    <= pfr_d;
        end
    end

`ifdef PAR_RX9_ERRCNT_EN
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (ERRCLR)
            errcnt_d = '0;
        else if (load && (pfr_q || !SIN) && (errcnt_q != '1))
            errcnt_d = errcnt_q + 1'b1;
    end

    always_ff @(posedge C) begin
        if (!R_N) errcnt_q <= '0;
        else      errcnt_q <= errcnt_d;
    end

    assign ERRCNT = errcnt_q;
`endif

    assign rx.DOUT   = dout_q;
    assign rx.PERR   = perr_q;
    assign rx.FERR   = ferr_q;
    assign rx.DVALID = dvalid_q;
    assign rx.OVR    = ovr_q;
    assign BUSY      = (state_q != IDLE);
endmodule
